// File: rtl/stall_pipe_n_pkg.sv
// Shared types and helpers for the stallable N-stage pipeline.
package stall_pipe_pkg;

    // Bits needed to count 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stall_pipe_n_if.sv
// Producer/consumer handshake bundle of the stallable pipeline.
interface stall_pipe_n_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    import stall_pipe_pkg::*;

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_allowin;
    logic [DEPTH-1:0]   stage_ready_go;
    logic               flush;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_allow;
    logic [DEPTH-1:0]   stage_valid;
    logic [CNT_W-1:0]   occupancy;

    // Driver side: producer, consumer and stall/flush control.
    modport master (
        output in_valid, in_data, stage_ready_go, flush, out_allow,
        input  in_allowin, out_valid, out_data, stage_valid, occupancy
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_data, stage_ready_go, flush, out_allow,
        output in_allowin, out_valid, out_data, stage_valid, occupancy
    );

endinterface

// File: rtl/stall_pipe_n_stage.sv
// One valid+data register stage with a valid/allowin handshake.
module stall_pipe_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_go_i,
    input  logic [WIDTH-1:0] prev_data_i,
    input  logic             ready_go_i,
    input  logic             next_allowin_i,
    input  logic             flush_i,
    output logic             allowin_o,
    output logic             go_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Stage can take a new item when empty or when its item leaves this cycle.
    assign allowin_o = !valid_q || (ready_go_i && next_allowin_i);
    assign go_o      = valid_q && ready_go_i;
    assign valid_o   = valid_q;
    assign data_o    = data_q;

    // Next valid/data: flush kills, allowin loads from the previous stage, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (allowin_o) begin
            valid_d = prev_go_i;
            if (prev_go_i) begin
                data_d = prev_data_i;
            end
        end
    end

    // Valid bit, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register; no reset needed since valid qualifies it.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/stall_pipe_n.sv
// Parametrised DEPTH-stage stallable pipeline with flush and occupancy count.
module stall_pipe_n
    import stall_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    stall_pipe_n_if.slave pipe_if
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [DEPTH-1:0] valid_vec;
    logic             first_allowin;
    logic             last_go;
    logic [WIDTH-1:0] last_data;
    logic             in_allowin_c;
    logic             out_valid_c;
    logic             accept;
    logic             xfer;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stage chain: each stage owns its handshake wires so the allowin ripple stays acyclic per signal.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             prev_go_w;
        logic [WIDTH-1:0] prev_data_w;
        logic             next_allowin_w;
        logic             allowin_w;
        logic             go_w;
        logic             valid_w;
        logic [WIDTH-1:0] data_w;

        if (i == 0) begin : g_head
            assign prev_go_w   = pipe_if.in_valid;
            assign prev_data_w = pipe_if.in_data;
        end else begin : g_body
            assign prev_go_w   = g_stage[i-1].go_w;
            assign prev_data_w = g_stage[i-1].data_w;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign next_allowin_w = pipe_if.out_allow;
        end else begin : g_link
            assign next_allowin_w = g_stage[i+1].allowin_w;
        end

        stall_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk           (clk),
            .rst           (rst),
            .prev_go_i     (prev_go_w),
            .prev_data_i   (prev_data_w),
            .ready_go_i    (pipe_if.stage_ready_go[i]),
            .next_allowin_i(next_allowin_w),
            .flush_i       (pipe_if.flush),
            .allowin_o     (allowin_w),
            .go_o          (go_w),
            .valid_o       (valid_w),
            .data_o        (data_w)
        );

        assign valid_vec[i] = valid_w;
    end

    assign first_allowin = g_stage[0].allowin_w;
    assign last_go       = g_stage[DEPTH-1].go_w;
    assign last_data     = g_stage[DEPTH-1].data_w;

    // Boundary handshakes: no transfer on either side completes during a flush.
    assign in_allowin_c = first_allowin && !pipe_if.flush;
    assign out_valid_c  = last_go && !pipe_if.flush;
    assign accept       = pipe_if.in_valid && in_allowin_c;
    assign xfer         = out_valid_c && pipe_if.out_allow;

    // Occupancy next value: cleared by flush, otherwise tracks accepts minus transfers.
    always_comb begin
        cnt_d = cnt_q;
        if (pipe_if.flush) begin
            cnt_d = '0;
        end else begin
            case ({accept, xfer})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pipe_if.in_allowin  = in_allowin_c;
    assign pipe_if.out_valid   = out_valid_c;
    assign pipe_if.out_data    = last_data;
    assign pipe_if.stage_valid = valid_vec;
    assign pipe_if.occupancy   = cnt_q;

endmodule

// File: tb/tb_stall_pipe_n.sv
// Bench for stall_pipe_n: cycle table for DEPTH=4, scoreboard on data/occupancy, DEPTH=1 sequence.
module tb_stall_pipe_n;

    localparam logic [3:0] F = 4'b1111;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] rgo;
        logic       fl;
        logic       oa;
        logic       ia;
        logic       ov;
        logic [3:0] sv;
        int         occ;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stall_pipe_n_if #(.WIDTH(32), .DEPTH(4)) bus4 ();
    stall_pipe_n_if #(.WIDTH(32), .DEPTH(1)) bus1 ();

    stall_pipe_n #(.WIDTH(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .pipe_if(bus4));
    stall_pipe_n #(.WIDTH(32), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .pipe_if(bus1));

    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        vec[$];
    logic [31:0] sb[$];
    logic        mon_en = 1'b0;
    int          seq = 1;

    function automatic void chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, got, want);
        end
    endfunction

    function automatic void add(input logic r, input logic iv, input logic [3:0] rgo, input logic fl,
                                input logic oa, input logic ia, input logic ov, input logic [3:0] sv,
                                input int occ);
        vec_t v;
        v.rst = r; v.iv = iv; v.rgo = rgo; v.fl = fl; v.oa = oa;
        v.ia = ia; v.ov = ov; v.sv = sv; v.occ = occ;
        vec.push_back(v);
    endfunction

    // Scoreboard on the DEPTH=4 pipe: order, no loss/duplication, occupancy bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("occ_vs_sb", seq, 32'(bus4.occupancy), 32'(sb.size()));
            chk("occ_vs_popcount", seq, 32'(bus4.occupancy), 32'($countones(bus4.stage_valid)));
            if (rst) begin
                sb.delete();
            end else if (bus4.flush) begin
                chk("flush_in_allowin", seq, 32'(bus4.in_allowin), 32'd0);
                chk("flush_out_valid", seq, 32'(bus4.out_valid), 32'd0);
                sb.delete();
            end else begin
                if (bus4.out_valid && bus4.out_allow) begin
                    if (sb.size() == 0) begin
                        chk("out_without_item", seq, 32'(bus4.out_data), 32'hxxxx_xxxx);
                    end else begin
                        chk("out_data_order", seq, bus4.out_data, sb.pop_front());
                    end
                end
                if (bus4.in_valid && bus4.in_allowin) begin
                    sb.push_back(bus4.in_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Test 1: back-to-back stream, no stalls.
        add(0,1,F,0,1, 1,0,4'b0000,0); add(0,1,F,0,1, 1,0,4'b0001,1);
        add(0,1,F,0,1, 1,0,4'b0011,2); add(0,1,F,0,1, 1,0,4'b0111,3);
        for (int k = 0; k < 6; k++) add(0,1,F,0,1, 1,1,4'b1111,4);
        add(0,0,F,0,1, 1,1,4'b1111,4); add(0,0,F,0,1, 1,1,4'b1110,3);
        add(0,0,F,0,1, 1,1,4'b1100,2); add(0,0,F,0,1, 1,1,4'b1000,1);
        add(0,0,F,0,1, 1,0,4'b0000,0);
        // Test 2: consumer backpressure fills the pipe, then drains in order.
        add(0,1,F,0,0, 1,0,4'b0000,0); add(0,1,F,0,0, 1,0,4'b0001,1);
        add(0,1,F,0,0, 1,0,4'b0011,2); add(0,1,F,0,0, 1,0,4'b0111,3);
        add(0,1,F,0,0, 0,1,4'b1111,4); add(0,1,F,0,0, 0,1,4'b1111,4);
        add(0,0,F,0,1, 1,1,4'b1111,4); add(0,0,F,0,1, 1,1,4'b1110,3);
        add(0,0,F,0,1, 1,1,4'b1100,2); add(0,0,F,0,1, 1,1,4'b1000,1);
        add(0,0,F,0,1, 1,0,4'b0000,0);
        // Test 3: stage 1 stalls for 3 cycles; stages 2-3 drain, bubble, then resume.
        add(0,1,F,0,1, 1,0,4'b0000,0); add(0,1,F,0,1, 1,0,4'b0001,1);
        add(0,1,F,0,1, 1,0,4'b0011,2); add(0,1,F,0,1, 1,0,4'b0111,3);
        add(0,1,4'b1101,0,1, 0,1,4'b1111,4);
        add(0,1,4'b1101,0,1, 0,1,4'b1011,3);
        add(0,1,4'b1101,0,1, 0,0,4'b0011,2);
        add(0,1,F,0,1, 1,0,4'b0011,2); add(0,1,F,0,1, 1,0,4'b0111,3);
        add(0,0,F,0,1, 1,1,4'b1111,4); add(0,0,F,0,1, 1,1,4'b1110,3);
        add(0,0,F,0,1, 1,1,4'b1100,2); add(0,0,F,0,1, 1,1,4'b1000,1);
        add(0,0,F,0,1, 1,0,4'b0000,0);
        // Test 4: flush with three items in flight.
        add(0,1,F,0,1, 1,0,4'b0000,0); add(0,1,F,0,1, 1,0,4'b0001,1);
        add(0,1,F,0,1, 1,0,4'b0011,2);
        add(0,1,F,1,1, 0,0,4'b0111,3);
        add(0,0,F,0,1, 1,0,4'b0000,0);
        // Test 5: reset mid-stream, then a clean restart.
        add(0,1,F,0,1, 1,0,4'b0000,0); add(0,1,F,0,1, 1,0,4'b0001,1);
        add(1,1,F,0,1, 1,0,4'b0011,2);
        add(0,1,F,0,1, 1,0,4'b0000,0); add(0,0,F,0,1, 1,0,4'b0001,1);
        add(0,0,F,0,1, 1,0,4'b0010,1); add(0,0,F,0,1, 1,0,4'b0100,1);
        add(0,0,F,0,1, 1,1,4'b1000,1); add(0,0,F,0,1, 1,0,4'b0000,0);

        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.stage_ready_go = F;
        bus4.flush = 1'b0; bus4.out_allow = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.stage_ready_go = 1'b1;
        bus1.flush = 1'b0; bus1.out_allow = 1'b1;
        repeat (2) @(posedge clk);
        mon_en = 1'b1;

        for (int r = 0; r < vec.size(); r++) begin
            @(posedge clk); #1;
            rst                 = vec[r].rst;
            bus4.in_valid       = vec[r].iv;
            bus4.in_data        = 32'(seq);
            bus4.stage_ready_go = vec[r].rgo;
            bus4.flush          = vec[r].fl;
            bus4.out_allow      = vec[r].oa;
            seq++;
            @(negedge clk);
            chk("in_allowin", r, 32'(bus4.in_allowin), 32'(vec[r].ia));
            chk("out_valid", r, 32'(bus4.out_valid), 32'(vec[r].ov));
            chk("stage_valid", r, 32'(bus4.stage_valid), 32'(vec[r].sv));
            chk("occupancy", r, 32'(bus4.occupancy), 32'(vec[r].occ));
        end

        // Random soak with stalls, backpressure and occasional flush.
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            bus4.in_valid = ($urandom_range(0, 3) != 0);
            bus4.in_data  = 32'(seq);
            for (int j = 0; j < 4; j++) bus4.stage_ready_go[j] = ($urandom_range(0, 3) != 0);
            bus4.out_allow = ($urandom_range(0, 3) != 0);
            bus4.flush     = ($urandom_range(0, 39) == 0);
            seq++;
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus4.in_valid = 1'b0; bus4.stage_ready_go = F; bus4.out_allow = 1'b1; bus4.flush = 1'b0;
        end
        @(negedge clk);
        chk("drain_empty", 0, 32'(sb.size()), 32'd0);
        chk("drain_occupancy", 0, 32'(bus4.occupancy), 32'd0);

        // Test 6: DEPTH=1 under full streaming passes one item per cycle.
        @(posedge clk); #1;
        bus1.in_valid = 1'b1; bus1.in_data = 32'd200; bus1.out_allow = 1'b1;
        @(negedge clk);
        chk("d1_fill_in_allowin", 0, 32'(bus1.in_allowin), 32'd1);
        chk("d1_fill_out_valid", 0, 32'(bus1.out_valid), 32'd0);
        chk("d1_fill_occupancy", 0, 32'(bus1.occupancy), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus1.in_data = 32'(200 + k);
            @(negedge clk);
            chk("d1_in_allowin", k, 32'(bus1.in_allowin), 32'd1);
            chk("d1_out_valid", k, 32'(bus1.out_valid), 32'd1);
            chk("d1_out_data", k, bus1.out_data, 32'(200 + k - 1));
            chk("d1_occupancy", k, 32'(bus1.occupancy), 32'd1);
            chk("d1_stage_valid", k, 32'(bus1.stage_valid), 32'd1);
        end
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("d1_last_out_valid", 7, 32'(bus1.out_valid), 32'd1);
        chk("d1_last_out_data", 7, bus1.out_data, 32'd206);
        @(posedge clk); #1;
        @(negedge clk);
        chk("d1_empty_out_valid", 8, 32'(bus1.out_valid), 32'd0);
        chk("d1_empty_occupancy", 8, 32'(bus1.occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
